input_mem: RTL and testbench
============================

Name: input_mem

Overview:
- APB-programmed 1024x32 source buffer that replays its contents as an AXI-Stream master.
- Software fills the buffer over APB, writes LENGTH, then writes CTRL.start.
- The block emits LENGTH words from buffer word 0 upward, with tlast on the final word, under full tready backpressure.
- Sits on the same APB bus as the capture buffer and feeds the datapath input.

Parameters:
- ADDR_W, 10, buffer word-address width; depth = 2**ADDR_W words.
- DATA_W, 32, stream and buffer data width; fixed at 32 for APB.

Ports:
- S_APB_aclk  in  1  single clock for APB and stream.
- S_APB_aresetn  in  1  asynchronous active-low reset.
- S_APB_paddr  in  32  byte address; [12]=0 selects buffer (word index [11:2]), [12]=1 selects registers ([3:2]).
- S_APB_psel  in  1  APB select.
- S_APB_penable  in  1  APB access phase.
- S_APB_pwrite  in  1  1=write.
- S_APB_pwdata  in  32  write data.
- S_APB_prdata  out  32  read data.
- S_APB_pready  out  1  transfer complete.
- S_APB_pslverr  out  1  error response.
- M_AXIS_tdata  out  32  stream data.
- M_AXIS_tvalid  out  1  data valid.
- M_AXIS_tlast  out  1  last word of frame.
- M_AXIS_tready  in  1  sink ready.

Behaviour:
- Reset (async, active-low): tvalid=0, tlast=0, tdata=0, pready=0, pslverr=0, prdata=0, state=IDLE, LENGTH=0, done=0. Buffer RAM contents are not reset.
- APB timing: one wait state. pready is registered as psel & penable & !pready. A transfer completes in the cycle pready=1; writes commit and prdata/pslverr are valid in that cycle, and prdata/pslverr are 0 when pready=0.
- Register map (paddr[12]=1):
  - 0x1000 CTRL: write bit0=1 -> start. Reads 0.
  - 0x1004 LENGTH: R/W, bits [ADDR_W:0], values clamp to 2**ADDR_W.
  - 0x1008 STATUS: bit0 busy (RO), bit1 done (sticky; W1C; cleared on start).
  - 0x100C: reads constant 0x0000_0400 (depth).
- Buffer region (paddr[12]=0): write-only through APB; reads return 0.
  - Buffer write while busy: dropped, pslverr=1.
  - Register writes while busy: LENGTH dropped with pslverr=1; start ignored with no error.
- RAM: simple dual port; APB write port, streamer read port with 1-cycle registered read.
- FSM:
  - IDLE: busy=0. Start with LENGTH=0 -> done=1, stay IDLE, no beats. Start with LENGTH>0 -> PRIME, read addr 0, cnt=0.
  - PRIME (1 cycle): RAM output settles -> STREAM; tvalid=1 from the next cycle.
  - STREAM: tdata = RAM output for word cnt; tlast = (cnt == LENGTH-1).
    - Read address = cnt+1 when handshake (tvalid & tready), else cnt. This sustains 1 word/cycle with no bubbles.
    - Handshake with tlast=1 -> tvalid=0, done=1, go to IDLE.
  - tvalid, tdata and tlast are held stable while tvalid & !tready (AXIS rule).
- Counter width ADDR_W+1. LENGTH=1024 streams words 0..1023 with no wrap.
- Reset asserted mid-frame: tvalid drops immediately (async); the frame is abandoned.
- Simultaneous STATUS W1C and frame completion in the same cycle: done=1 (set wins).

Decomposition:
- Shared package `apb_mem_pkg`:
  - Register offsets: CTRL, LENGTH, STATUS, DEPTH.
  - Region-select bit index (12).
  - STATUS bit positions.
  - FSM state enum {IDLE, PRIME, STREAM}.
- One sub-module: `sdp_ram` (simple dual-port, registered read, parameterised width/depth). It is reusable by the capture buffer.

Test Plan:
- Write 0xA0+i to buffer words 0..7, LENGTH=8, start, tready=1 -> 8 consecutive beats 0xA0..0xA7, 1 per cycle; tlast only on 0xA7; STATUS reads 0x2 afterwards.
- Same frame with tready toggling 1,0,0,1 repeating -> identical data sequence; tdata/tlast held stable during every stall; no word lost or duplicated.
- LENGTH=0, start -> no tvalid ever; STATUS=0x2 on the next read. Write STATUS=0x2 -> STATUS=0x0.
- LENGTH=1024 full-buffer frame -> 1024 beats; tlast on beat 1023 carrying word 1023.
- During busy: APB write to buffer word 3 -> pslverr=1 and the stream data is unaffected; second start ignored, no extra frame.
- Assert aresetn low at beat 4 of 8 -> tvalid=0 immediately. After release: STATUS=0, LENGTH=0, and a new frame streams correctly.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// apb_mem_pkg: shared register map, region select and FSM states for APB buffers
`timescale 1ns/1ps
package apb_mem_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_LENGTH = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_DEPTH  = 2'd3;
  localparam int REGION_BIT = 12;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_e;
endpackage

// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port
`timescale 1ns/1ps
module sdp_ram #(
  parameter int W  = 32,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [2**AW];
  // Write port commits on the clock; read data appears one cycle after the address
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/input_mem.sv
// input_mem: APB-filled source buffer replayed as an AXI-Stream frame
`timescale 1ns/1ps
module input_mem
  import apb_mem_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic              S_APB_aclk,
  input  logic              S_APB_aresetn,
  input  logic [31:0]       S_APB_paddr,
  input  logic              S_APB_psel,
  input  logic              S_APB_penable,
  input  logic              S_APB_pwrite,
  input  logic [DATA_W-1:0] S_APB_pwdata,
  output logic [DATA_W-1:0] S_APB_prdata,
  output logic              S_APB_pready,
  output logic              S_APB_pslverr,
  output logic [DATA_W-1:0] M_AXIS_tdata,
  output logic              M_AXIS_tvalid,
  output logic              M_AXIS_tlast,
  input  logic              M_AXIS_tready
);
  localparam int DEPTH = 1 << ADDR_W;
  state_e              state_q, state_d;
  logic                pready_q;
  logic [ADDR_W:0]     cnt_q, cnt_d, len_q, len_d, len_wr;
  logic                done_q, done_d;
  logic                xfer, wr, reg_sel, busy, hs, last, start, buf_we, len_we, w1c;
  logic [1:0]          off;
  logic [ADDR_W-1:0]   rd_addr;
  logic [DATA_W-1:0]   ram_q, rdata, status;

  assign xfer    = S_APB_psel & S_APB_penable & pready_q;
  assign wr      = xfer & S_APB_pwrite;
  assign reg_sel = S_APB_paddr[REGION_BIT];
  assign off     = S_APB_paddr[3:2];
  assign busy    = state_q != IDLE;
  assign buf_we  = wr & !reg_sel & !busy;
  assign len_we  = wr & reg_sel & off == REG_LENGTH & !busy;
  assign start   = wr & reg_sel & off == REG_CTRL & S_APB_pwdata[0] & !busy;
  assign w1c     = wr & reg_sel & off == REG_STATUS & S_APB_pwdata[ST_DONE];
  assign hs      = M_AXIS_tvalid & M_AXIS_tready;
  assign last    = cnt_q == len_q - 1'b1;
  assign len_wr  = (S_APB_pwdata > DATA_W'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : S_APB_pwdata[ADDR_W:0];

  assign S_APB_pready  = pready_q;
  assign S_APB_pslverr = pready_q & S_APB_pwrite & busy & (!reg_sel | off == REG_LENGTH);
  assign S_APB_prdata  = (pready_q & !S_APB_pwrite & reg_sel) ? rdata : '0;

  sdp_ram #(.W(DATA_W), .AW(ADDR_W)) u_ram (
    .clk_i   (S_APB_aclk),
    .we_i    (buf_we),
    .waddr_i (S_APB_paddr[ADDR_W+1:2]),
    .wdata_i (S_APB_pwdata),
    .raddr_i (rd_addr),
    .rdata_o (ram_q)
  );

  // State, counter, length, done and the single APB wait state
  always_ff @(posedge S_APB_aclk or negedge S_APB_aresetn) begin
    if (!S_APB_aresetn) begin
      state_q  <= IDLE;
      pready_q <= 1'b0;
      cnt_q    <= '0;
      len_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pready_q <= S_APB_psel & S_APB_penable & !pready_q;
      cnt_q    <= cnt_d;
      len_q    <= len_d;
      done_q   <= done_d;
    end
  end

  // Next state: PRIME gives the registered RAM read one cycle before the first beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (start && len_q != '0) ? PRIME : IDLE;
      PRIME:   state_d = STREAM;
      default: state_d = (hs && last) ? IDLE : STREAM;
    endcase
  end

  // Outputs and datapath: prefetch the next word on handshake so beats run back to back
  always_comb begin
    M_AXIS_tvalid = state_q == STREAM;
    M_AXIS_tlast  = M_AXIS_tvalid & last;
    M_AXIS_tdata  = M_AXIS_tvalid ? ram_q : '0;
    cnt_d         = (state_q == IDLE) ? '0 : hs ? cnt_q + 1'b1 : cnt_q;
    rd_addr       = hs ? cnt_q[ADDR_W-1:0] + 1'b1 : cnt_q[ADDR_W-1:0];
    len_d         = len_we ? len_wr : len_q;
    done_d        = (start & len_q == '0) | (hs & last) | (done_q & !start & !w1c);
    status        = '0;
    status[ST_BUSY] = busy;
    status[ST_DONE] = done_q;
    rdata = off == REG_LENGTH ? DATA_W'(len_q) :
            off == REG_STATUS ? status :
            off == REG_DEPTH  ? DATA_W'(DEPTH) : '0;
  end
endmodule

// File: tb/tb_input_mem.sv
// tb_input_mem: randomized self-checking bench for the APB-to-AXIS source buffer
`timescale 1ns/1ps
module tb_input_mem;
  logic        clk = 0, rst_n = 0;
  logic [31:0] paddr, pwdata, prdata, tdata;
  logic        psel, penable, pwrite, pready, pslverr, tvalid, tlast, tready;
  int          checks = 0, errors = 0;
  logic [31:0] mem_m [1024];
  logic [31:0] q_data [$];
  logic        q_last [$];
  int          q_cyc [$];
  int          cyc = 0, stall_bad = 0;
  logic        pstall = 0, plast = 0;
  logic [31:0] pdata = 0;

  input_mem dut (
    .S_APB_aclk(clk), .S_APB_aresetn(rst_n), .S_APB_paddr(paddr), .S_APB_psel(psel),
    .S_APB_penable(penable), .S_APB_pwrite(pwrite), .S_APB_pwdata(pwdata),
    .S_APB_prdata(prdata), .S_APB_pready(pready), .S_APB_pslverr(pslverr),
    .M_AXIS_tdata(tdata), .M_AXIS_tvalid(tvalid), .M_AXIS_tlast(tlast), .M_AXIS_tready(tready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst_n) pstall = 0;
    else begin
      if (pstall && !(tvalid === 1'b1 && tdata === pdata && tlast === plast)) stall_bad++;
      if (tvalid && tready) begin
        q_data.push_back(tdata);
        q_last.push_back(tlast);
        q_cyc.push_back(cyc);
      end
      pstall = tvalid & !tready;
      pdata  = tdata;
      plast  = tlast;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic apb_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output logic [31:0] rd, output logic err);
    int n = 0;
    @(posedge clk); #1 psel = 1; penable = 0; pwrite = w; paddr = a; pwdata = d;
    @(posedge clk); #1 penable = 1;
    for (n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (pready) break;
    end
    rd = prdata; err = pslverr;
    if (!pready) begin
      checks++; errors++;
      $display("FAIL apb_timeout addr %h pready never rose", a);
    end
    @(posedge clk); #1 psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
    logic [31:0] rd;
    apb_xfer(1'b1, a, d, rd, err);
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    logic err;
    apb_xfer(1'b0, a, 32'h0, d, err);
  endtask

  task automatic clear_q();
    q_data.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic run_stream(input int n, input int mode);
    for (int k = 0; k < 4 * n + 40; k++) begin
      @(posedge clk); #1;
      tready = mode == 0 ? 1'b1 : mode == 1 ? (k % 4 == 0 || k % 4 == 3) : 1'($urandom % 2);
      if (q_data.size() >= n) break;
    end
    tready = 1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({tvalid, tlast, pready, pslverr} !== 4'b0 || tdata !== 0 || prdata !== 0) begin
      errors++;
      $display("FAIL reset_outputs got v%b l%b rdy%b err%b d%h rd%h want all 0",
               tvalid, tlast, pready, pslverr, tdata, prdata);
    end
    rst_n = 1;
    apb_read(32'h1004, rd); checks++;
    if (rd !== 0) begin errors++; $display("FAIL reset_length got %h want 0", rd); end
    apb_read(32'h1008, rd); checks++;
    if (rd !== 0) begin errors++; $display("FAIL reset_status got %h want 0", rd); end
    apb_read(32'h100C, rd); checks++;
    if (rd !== 32'h400) begin errors++; $display("FAIL depth_reg got %h want 400", rd); end
    apb_read(32'h1000, rd); checks++;
    if (rd !== 0) begin errors++; $display("FAIL ctrl_read got %h want 0", rd); end
    apb_read(32'h0010, rd); checks++;
    if (rd !== 0) begin errors++; $display("FAIL buffer_read got %h want 0", rd); end
  endtask

  task automatic test_basic();
    logic err; logic [31:0] rd;
    tready = 1;
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = 32'hA0 + i;
      apb_write(i * 4, mem_m[i], err);
    end
    apb_write(32'h1004, 8, err);
    clear_q();
    apb_write(32'h1000, 1, err);
    run_stream(8, 0);
    checks++;
    if (q_data.size() != 8) begin errors++; $display("FAIL basic_count got %0d want 8", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      checks++;
      if (q_data[i] !== mem_m[i] || q_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL basic_beat%0d got %h last %b want %h last %b", i, q_data[i], q_last[i], mem_m[i], i == 7);
      end
    end
    checks++;
    if (q_cyc.size() < 8 || q_cyc[7] - q_cyc[0] != 7) begin
      errors++; $display("FAIL basic_rate beats not on consecutive cycles");
    end
    apb_read(32'h1008, rd); checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL basic_status got %h want 2", rd); end
  endtask

  task automatic test_backpressure();
    logic err;
    stall_bad = 0;
    clear_q();
    apb_write(32'h1000, 1, err);
    run_stream(8, 1);
    checks++;
    if (q_data.size() != 8) begin errors++; $display("FAIL bp_count got %0d want 8", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      checks++;
      if (q_data[i] !== mem_m[i] || q_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL bp_beat%0d got %h last %b want %h last %b", i, q_data[i], q_last[i], mem_m[i], i == 7);
      end
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_bad); end
  endtask

  task automatic test_zero_len();
    logic err; logic [31:0] rd;
    apb_write(32'h1008, 2, err);
    apb_read(32'h1008, rd); checks++;
    if (rd !== 0) begin errors++; $display("FAIL zl_clear_before got %h want 0", rd); end
    apb_write(32'h1004, 0, err);
    clear_q();
    tready = 1;
    apb_write(32'h1000, 1, err);
    repeat (20) @(posedge clk);
    checks++;
    if (q_data.size() != 0) begin errors++; $display("FAIL zl_beats got %0d want 0", q_data.size()); end
    apb_read(32'h1008, rd); checks++;
    if (rd !== 32'h2) begin errors++; $display("FAIL zl_status got %h want 2", rd); end
    apb_write(32'h1008, 2, err);
    apb_read(32'h1008, rd); checks++;
    if (rd !== 0) begin errors++; $display("FAIL zl_w1c got %h want 0", rd); end
  endtask

  task automatic test_busy();
    logic err; logic [31:0] rd;
    tready = 0;
    for (int i = 0; i < 16; i++) begin
      mem_m[i] = $urandom;
      apb_write(i * 4, mem_m[i], err);
    end
    apb_write(32'h1004, 16, err);
    clear_q();
    apb_write(32'h1000, 1, err);
    apb_read(32'h1008, rd); checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL busy_status got %h want 1", rd); end
    apb_write(32'h000C, 32'hDEAD_BEEF, err); checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL busy_buf_err got %b want 1", err); end
    apb_write(32'h1004, 5, err); checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL busy_len_err got %b want 1", err); end
    apb_write(32'h1000, 1, err); checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL busy_start_err got %b want 0", err); end
    apb_read(32'h1004, rd); checks++;
    if (rd !== 16) begin errors++; $display("FAIL busy_len_kept got %h want 10", rd); end
    stall_bad = 0;
    run_stream(16, 2);
    checks++;
    if (q_data.size() != 16) begin errors++; $display("FAIL busy_count got %0d want 16", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 16; i++) begin
      checks++;
      if (q_data[i] !== mem_m[i] || q_last[i] !== (i == 15)) begin
        errors++;
        $display("FAIL busy_beat%0d got %h last %b want %h last %b", i, q_data[i], q_last[i], mem_m[i], i == 15);
      end
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL busy_stable got %0d unstable stalls want 0", stall_bad); end
  endtask

  task automatic test_full();
    logic err; logic [31:0] rd;
    int bad = 0;
    for (int i = 0; i < 1024; i++) begin
      mem_m[i] = $urandom;
      apb_write(i * 4, mem_m[i], err);
    end
    apb_write(32'h1004, 5000, err);
    apb_read(32'h1004, rd); checks++;
    if (rd !== 32'h400) begin errors++; $display("FAIL full_clamp got %h want 400", rd); end
    clear_q();
    apb_write(32'h1000, 1, err);
    run_stream(1024, 2);
    checks++;
    if (q_data.size() != 1024) begin errors++; $display("FAIL full_count got %0d want 1024", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 1024; i++) begin
      checks++;
      if (q_data[i] !== mem_m[i] || q_last[i] !== (i == 1023)) begin
        errors++; bad++;
        if (bad < 5) $display("FAIL full_beat%0d got %h last %b want %h last %b", i, q_data[i], q_last[i], mem_m[i], i == 1023);
      end
    end
  endtask

  task automatic test_random();
    logic err;
    for (int f = 0; f < 4; f++) begin
      int n = $urandom_range(1, 40);
      for (int i = 0; i < n; i++) begin
        mem_m[i] = $urandom;
        apb_write(i * 4, mem_m[i], err);
      end
      apb_write(32'h1004, n, err);
      clear_q();
      apb_write(32'h1000, 1, err);
      run_stream(n, 2);
      checks++;
      if (q_data.size() != n) begin errors++; $display("FAIL rnd%0d_count got %0d want %0d", f, q_data.size(), n); end
      for (int i = 0; i < q_data.size() && i < n; i++) begin
        checks++;
        if (q_data[i] !== mem_m[i] || q_last[i] !== (i == n - 1)) begin
          errors++;
          $display("FAIL rnd%0d_beat%0d got %h last %b want %h last %b", f, i, q_data[i], q_last[i], mem_m[i], i == n - 1);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic err; logic [31:0] rd;
    tready = 1;
    apb_write(32'h1004, 8, err);
    clear_q();
    apb_write(32'h1000, 1, err);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (q_data.size() >= 4) break;
    end
    #1 rst_n = 0;
    #1 checks++;
    if (tvalid !== 1'b0 || tdata !== 0) begin
      errors++; $display("FAIL rstmid_tvalid got v%b d%h want v0 d0", tvalid, tdata);
    end
    @(posedge clk); #1 rst_n = 1;
    apb_read(32'h1008, rd); checks++;
    if (rd !== 0) begin errors++; $display("FAIL rstmid_status got %h want 0", rd); end
    apb_read(32'h1004, rd); checks++;
    if (rd !== 0) begin errors++; $display("FAIL rstmid_length got %h want 0", rd); end
    apb_write(32'h1004, 8, err);
    clear_q();
    apb_write(32'h1000, 1, err);
    run_stream(8, 0);
    checks++;
    if (q_data.size() != 8) begin errors++; $display("FAIL rstmid_count got %0d want 8", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 8; i++) begin
      checks++;
      if (q_data[i] !== mem_m[i] || q_last[i] !== (i == 7)) begin
        errors++;
        $display("FAIL rstmid_beat%0d got %h last %b want %h last %b", i, q_data[i], q_last[i], mem_m[i], i == 7);
      end
    end
  endtask

  initial begin
    psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; tready = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_zero_len();
    test_busy();
    test_full();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
